// File: rtl/fec_pkg.sv
// Shared FEC/RF definitions: serializer state encoding, sync word and frame format geometry.
package fec_pkg;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_SYNC = 2'd1,
    SER_FLAG = 2'd2,
    SER_DATA = 2'd3
  } ser_state_e;

  localparam int                     RF_SYNC_WIDTH = 8;
  localparam logic [RF_SYNC_WIDTH-1:0] RF_SYNC_WORD = 8'hD5;

  localparam int RF_FMT0_BITS = 80;
  localparam int RF_FMT1_BITS = 24;
  localparam int RF_FMT1_ROWS = 4;
  localparam int RF_FMT1_COLS = 6;

endpackage

// File: rtl/rf_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the last cycle of each bit.
module rf_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Held at zero while disabled so every frame starts on a full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_frame_serializer.sv
// Captures one scrambled frame and shifts it out as sync word, format flag, then LSB-first payload.
module rf_frame_serializer
  import fec_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    DATA_DEPTH   = 8,
  parameter int                    CLKS_PER_BIT = 4,
  parameter int                    SYNC_WIDTH   = RF_SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD    = RF_SYNC_WORD
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  frame_valid,
  output logic                                  frame_ready,
  input  logic                                  enc_used,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
  output logic                                  tx_bit,
  output logic                                  tx_en,
  output logic                                  busy,
  output logic                                  done
);

  localparam logic [1:0] IDLE = SER_IDLE;
  localparam logic [1:0] SYNC = SER_SYNC;
  localparam logic [1:0] FLAG = SER_FLAG;
  localparam logic [1:0] DATA = SER_DATA;

  localparam int FMT0_BITS = DATA_DEPTH * DATA_WIDTH;
  localparam int MAX_BITS  = (SYNC_WIDTH > FMT0_BITS) ? SYNC_WIDTH : FMT0_BITS;
  localparam int BIT_W     = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int ROW_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int COL_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]                            state;
  logic [BIT_W-1:0]                      bit_idx;
  logic [ROW_W-1:0]                      row;
  logic [COL_W-1:0]                      col;
  logic                                  done_q;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] frame_q;
  logic                                  fmt_q;
  logic [SYNC_WIDTH-1:0]                 sync_sh;
  logic                                  accept;
  logic                                  bit_tick;
  logic [BIT_W-1:0]                      last_bit;
  logic [COL_W-1:0]                      last_col;

  assign accept   = frame_valid && (state == IDLE);
  assign last_bit = fmt_q ? BIT_W'(RF_FMT1_BITS - 1) : BIT_W'(FMT0_BITS - 1);
  assign last_col = fmt_q ? COL_W'(RF_FMT1_COLS - 1) : COL_W'(DATA_WIDTH - 1);

  rf_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      row     <= '0;
      col     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SYNC;
            bit_idx <= '0;
            row     <= '0;
            col     <= '0;
          end
        end
        SYNC: begin
          if (bit_tick) begin
            if (bit_idx == BIT_W'(SYNC_WIDTH - 1)) begin
              state   <= FLAG;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        FLAG: begin
          if (bit_tick) state <= DATA;
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == last_bit) begin
              state   <= IDLE;
              done_q  <= 1'b1;
              bit_idx <= '0;
              row     <= '0;
              col     <= '0;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              // Short format drops the upper columns, so the row steps early.
              if (col == last_col) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame data is only consumed outside IDLE, after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_q <= par_in;
      fmt_q   <= enc_used;
      sync_sh <= SYNC_WORD;
    end else if ((state == SYNC) && bit_tick) begin
      sync_sh <= sync_sh << 1;
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      SYNC:    tx_bit = sync_sh[SYNC_WIDTH-1];
      FLAG:    tx_bit = fmt_q;
      DATA:    tx_bit = frame_q[row][col];
      default: tx_bit = 1'b1;
    endcase
  end

  assign tx_en       = (state != IDLE);
  assign busy        = (state != IDLE);
  assign frame_ready = (state == IDLE);
  assign done        = done_q;

endmodule
